// File: rtl/name_pkg.sv
// name_pkg: shared pattern table and types for the
// "James Rhodes " coder/matcher pair.
package name_pkg;

  localparam int NAME_LEN = 13;

  typedef logic [6:0] char_t;
  typedef logic [0:NAME_LEN-1] pos_t;

  localparam char_t CHAR_J = 7'h4A;

  localparam char_t PATTERN [0:NAME_LEN-1] = '{
    7'h4A, 7'h61, 7'h6D, 7'h65, 7'h73,
    7'h20, 7'h52, 7'h68, 7'h6F, 7'h64,
    7'h65, 7'h73, 7'h20
  };

  localparam pos_t POS0 = 13'b1_0000_0000_0000;
  localparam pos_t POS1 = 13'b0_1000_0000_0000;

endpackage

// File: rtl/name_rom.sv
// name_rom: one-hot position to expected ASCII character,
// the inverse of the transmit-side coder.
module name_rom
  import name_pkg::*;
(
  input  pos_t  Q,
  output char_t ascii
);

  always_comb begin
    ascii = '0;
    for (int i = 0; i < NAME_LEN; i++) begin
      ascii = ascii | (PATTERN[i] & {7{Q[i]}});
    end
  end

endmodule

// File: rtl/name_matcher.sv
// name_matcher: tracks position in the repeating name stream,
// pulses match per pattern, flags breaks once locked.
module name_matcher
  import name_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             valid,
  input  logic [6:0]       ascii,
  output pos_t             Q,
  output logic             match,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt
);

  char_t            exp_c;
  logic             legal;
  logic             hit;
  pos_t             q_nxt;
  logic             match_nxt;
  logic             lock_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  name_rom u_rom (
    .Q     (Q),
    .ascii (exp_c)
  );

  assign legal = $onehot(Q);
  assign hit   = (ascii == exp_c);

  always_comb begin
    q_nxt     = Q;
    match_nxt = 1'b0;
    lock_nxt  = locked;
    err_nxt   = 1'b0;
    cnt_nxt   = match_cnt;
    if (valid) begin
      if (!legal) begin
        q_nxt = POS0;
      end else if (hit) begin
        q_nxt = {Q[NAME_LEN-1], Q[0:NAME_LEN-2]};
        if (Q[NAME_LEN-1]) begin
          match_nxt = 1'b1;
          lock_nxt  = 1'b1;
          if (match_cnt != '1)
            cnt_nxt = match_cnt + 1'b1;
        end
      end else begin
        // 'J' appears only at position 0, so a miss on 'J'
        // has already consumed the first pattern character.
        q_nxt    = (ascii == CHAR_J) ? POS1 : POS0;
        err_nxt  = locked;
        lock_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Q         <= POS0;
      match     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      match_cnt <= '0;
    end else begin
      Q         <= q_nxt;
      match     <= match_nxt;
      locked    <= lock_nxt;
      err       <= err_nxt;
      match_cnt <= cnt_nxt;
    end
  end

endmodule
